// File: rtl/cardinal_pkg.sv
// Shared constants for the cardinal NIC: data width, register map and packet field positions.
package cardinal_pkg;

   localparam int DATA_WIDTH = 64;

   localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
   localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
   localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
   localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

   localparam int VC_BIT      = 63;
   localparam int DIR_BIT     = 62;
   localparam int HOP_MSB     = 55;
   localparam int HOP_LSB     = 48;
   localparam int PAYLOAD_MSB = 31;
   localparam int PAYLOAD_LSB = 0;

endpackage

// File: rtl/nic_channel_buffer.sv
// One-entry packet buffer with a full flag; load captures data and sets full, clr drops full.
module nic_channel_buffer #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  full
);

   // The parent only loads an empty entry and only clears a full one, so load taking priority is never observable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q    <= '0;
         full <= 1'b0;
      end else if (load) begin
         q    <= d;
         full <= 1'b1;
      end else if (clr) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/cardinal_nic.sv
// Processor-facing register file plus router PE-port handshake for the cardinal NIC.
module cardinal_nic
   import cardinal_pkg::*;
#(
   parameter int DATA_WIDTH = cardinal_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            addr,
   input  logic [DATA_WIDTH-1:0] d_in,
   output logic [DATA_WIDTH-1:0] d_out,
   input  logic                  nicEn,
   input  logic                  nicWrEn,
   input  logic                  net_si,
   output logic                  net_ri,
   input  logic [DATA_WIDTH-1:0] net_di,
   output logic                  net_so,
   input  logic                  net_ro,
   output logic [DATA_WIDTH-1:0] net_do,
   input  logic                  net_polarity
);

   logic [DATA_WIDTH-1:0] in_buf;
   logic [DATA_WIDTH-1:0] out_buf;
   logic                  in_full;
   logic                  out_full;
   logic                  rd_en;
   logic                  wr_en;
   logic                  in_load;
   logic                  in_clr;
   logic                  out_load;

   assign rd_en = nicEn & ~nicWrEn;
   assign wr_en = nicEn & nicWrEn;

   assign net_ri  = ~in_full;
   assign in_load = net_si & net_ri;
   assign in_clr  = rd_en & (addr == ADDR_IN_BUF) & in_full;

   // A write landing while full is dropped; the processor must poll out-status first.
   assign out_load = wr_en & (addr == ADDR_OUT_BUF) & ~out_full;

   assign net_so = out_full & net_ro & (out_buf[DATA_WIDTH-1] == net_polarity);
   assign net_do = net_so ? out_buf : '0;

   nic_channel_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_in_chan (
      .clk  (clk),
      .rst  (rst),
      .load (in_load),
      .clr  (in_clr),
      .d    (net_di),
      .q    (in_buf),
      .full (in_full)
   );

   nic_channel_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_out_chan (
      .clk  (clk),
      .rst  (rst),
      .load (out_load),
      .clr  (net_so),
      .d    (d_in),
      .q    (out_buf),
      .full (out_full)
   );

   always_comb begin
      d_out = '0;
      if (rd_en) begin
         case (addr)
            ADDR_IN_BUF:   d_out = in_buf;
            ADDR_IN_STAT:  d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
            ADDR_OUT_BUF:  d_out = '0;
            ADDR_OUT_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
            default:       d_out = '0;
         endcase
      end
   end

endmodule
